// File: rtl/mdu_iter.sv
// ============================================================================
// mdu_iter : iterative RV32M multiply/divide unit (shift-add / restoring div)
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module mdu_iter #(
  parameter int DATA_W = 32,
  parameter int BPC    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [4:0]        rd_in,
  output logic              stall_req,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        rd_out
);

  localparam int N  = DATA_W / BPC;
  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [DATA_W-1:0] c_min_neg = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] c_ones    = {DATA_W{1'b1}};

  logic [1:0]        r_state;
  logic [CW-1:0]     r_count;
  logic [2:0]        r_f3;
  logic              r_neg_a;
  logic              r_neg_b;
  logic [DATA_W-1:0] r_op;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [4:0]        r_tag;
  logic [DATA_W-1:0] r_result;
  logic [4:0]        r_rd_out;
  logic              r_done;

  // Operand decode while IDLE
  logic              w_is_div;
  logic              w_sgn_a;
  logic              w_sgn_b;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;
  logic              w_div0;
  logic              w_ovf;
  logic [DATA_W-1:0] w_fast_res;

  always_comb begin
    w_is_div = funct3[2];
    w_sgn_a  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    w_sgn_b  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    w_neg_a  = w_sgn_a & op_a[DATA_W-1];
    w_neg_b  = w_sgn_b & op_b[DATA_W-1];
    w_abs_a  = w_neg_a ? -op_a : op_a;
    w_abs_b  = w_neg_b ? -op_b : op_b;
    w_div0   = w_is_div && (op_b == '0);
    w_ovf    = w_is_div && !funct3[0] && (op_a == c_min_neg) && (op_b == c_ones);
    if (w_div0)
      w_fast_res = funct3[1] ? op_a : c_ones;
    else
      w_fast_res = funct3[1] ? '0 : op_a;
  end

  // One compute edge retires BPC bits; hi/lo double as product or remainder/quotient
  logic [DATA_W-1:0] w_hi_nx;
  logic [DATA_W-1:0] w_lo_nx;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_sh;
  logic              w_ge;

  always_comb begin
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    w_sum   = '0;
    w_sh    = '0;
    w_ge    = 1'b0;
    for (int k = 0; k < BPC; k++) begin
      if (r_f3[2]) begin
        w_sh    = {w_hi_nx, w_lo_nx[DATA_W-1]};
        w_ge    = (w_sh >= {1'b0, r_op});
        if (w_ge)
          w_sh = w_sh - {1'b0, r_op};
        w_hi_nx = w_sh[DATA_W-1:0];
        w_lo_nx = {w_lo_nx[DATA_W-2:0], w_ge};
      end else begin
        w_sum   = {1'b0, w_hi_nx} + (w_lo_nx[0] ? {1'b0, r_op} : {(DATA_W+1){1'b0}});
        w_lo_nx = {w_sum[0], w_lo_nx[DATA_W-1:1]};
        w_hi_nx = w_sum[DATA_W:1];
      end
    end
  end

  // Sign correction and result selection
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_fix_res;

  always_comb begin
    w_prod = {r_hi, r_lo};
    if (r_neg_a ^ r_neg_b)
      w_prod = -w_prod;
    if (!r_f3[2])
      w_fix_res = (r_f3[1:0] == 2'b00) ? w_prod[DATA_W-1:0] : w_prod[2*DATA_W-1:DATA_W];
    else if (!r_f3[1])
      w_fix_res = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
    else
      w_fix_res = r_neg_a ? -r_hi : r_hi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_f3     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_tag    <= '0;
      r_result <= '0;
      r_rd_out <= '0;
      r_done   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_f3    <= funct3;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_tag   <= rd_in;
            r_count <= '0;
            r_hi    <= '0;
            if (w_div0 || w_ovf) begin
              r_result <= w_fast_res;
              r_rd_out <= rd_in;
              r_state  <= S_DONE;
            end else begin
              r_op    <= w_is_div ? w_abs_b : w_abs_a;
              r_lo    <= w_is_div ? w_abs_a : w_abs_b;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_hi    <= w_hi_nx;
          r_lo    <= w_lo_nx;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(N-1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_rd_out <= r_tag;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_CALC) || (r_state == S_FIX);
  assign stall_req = !reset && (((r_state == S_IDLE) && start && !flush) || busy);
  assign done      = r_done;
  assign result    = r_result;
  assign rd_out    = r_rd_out;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
// tb_mdu_iter : directed vector bench for mdu_iter (BPC=1 and BPC=4 instances)
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset, flush, start, start4;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;

  logic        stall1, busy1, done1;
  logic [31:0] res1;
  logic [4:0]  rd1;
  logic        stall4, busy4, done4;
  logic [31:0] res4;
  logic [4:0]  rd4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mdu_iter #(.DATA_W(32), .BPC(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall_req(stall1), .busy(busy1),
    .done(done1), .result(res1), .rd_out(rd1)
  );

  mdu_iter #(.DATA_W(32), .BPC(4)) u4 (
    .clk(clk), .reset(reset), .flush(flush), .start(start4), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall_req(stall4), .busy(busy4),
    .done(done4), .result(res4), .rd_out(rd4)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int stalls);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    #1;
    stalls = stall1 ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (!done1 && lat < 100) begin
      if (stall1) stalls++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat, stalls, seen_done;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34};
    vecs[2]  = '{3'b011, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 34};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 34};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       34};
    vecs[7]  = '{3'b101, 32'd123,      32'd0,        5'd12, 32'hFFFFFFFF, 1};
    vecs[8]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 1};
    vecs[9]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1};
    vecs[10] = '{3'b111, 32'd123,      32'd0,        5'd15, 32'd123,      1};
    vecs[11] = '{3'b000, 32'h12345678, 32'h00000010, 5'd16, 32'h23456780, 34};
    vecs[12] = '{3'b111, 32'd100,      32'd7,        5'd17, 32'd2,        34};
    vecs[13] = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd18, 32'hFFFFFFFD, 34};
    vecs[14] = '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd19, 32'd1,        34};
    vecs[15] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFE, 34};

    // Reset held with start asserted: everything quiet
    reset = 1'b1; flush = 1'b0; start = 1'b1; start4 = 1'b0;
    funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1; rd_in = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done",  {31'd0, done1},  32'd0);
    check("reset_busy",  {31'd0, busy1},  32'd0);
    check("reset_stall", {31'd0, stall1}, 32'd0);
    check("reset_res",   res1,            32'd0);
    check("reset_rd",    {27'd0, rd1},    32'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, lat, stalls);
      check($sformatf("v%0d_lat", i),    lat,               vecs[i].lat);
      check($sformatf("v%0d_result", i), res1,              vecs[i].exp);
      check($sformatf("v%0d_rd", i),     {27'd0, rd1},      {27'd0, vecs[i].rd});
      check($sformatf("v%0d_stall", i),  stalls,            (vecs[i].lat == 1) ? 1 : vecs[i].lat);
      if (i == 0) begin
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done1}, 32'd0);
      end
    end

    // Flush then reset mid-division; next op must run cleanly
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd21; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      seen_done = 0;
      repeat (9) begin
        @(posedge clk);
        #1;
        if (done1) seen_done++;
      end
      @(negedge clk);
      if (pass == 0) flush = 1'b1; else reset = 1'b1;
      @(posedge clk);
      #1;
      if (done1) seen_done++;
      flush = 1'b0; reset = 1'b0;
      check($sformatf("abort%0d_busy", pass),  {31'd0, busy1},  32'd0);
      check($sformatf("abort%0d_stall", pass), {31'd0, stall1}, 32'd0);
      check($sformatf("abort%0d_nodone", pass), seen_done,      0);
      if (pass == 1) check("abort1_res_cleared", res1, 32'd0);
      run_op(3'b101, 32'd100, 32'd7, 5'd4, lat, stalls);
      check($sformatf("abort%0d_next_lat", pass), lat,          34);
      check($sformatf("abort%0d_next_res", pass), res1,         32'd14);
      check($sformatf("abort%0d_next_rd", pass),  {27'd0, rd1}, 32'd4);
    end

    // BPC=4: a second start mid-operation is ignored
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFFFFFD; rd_in = 5'd9; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 100) begin
      if (lat == 5) begin
        start4 = 1'b1; op_a = 32'd3; rd_in = 5'd1;
      end else begin
        start4 = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start4 = 1'b0;
    check("bpc4_lat",    lat,          10);
    check("bpc4_result", res4,         32'hFFFFFFEB);
    check("bpc4_rd",     {27'd0, rd4}, 32'd9);
    seen_done = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done4) seen_done++;
    end
    check("bpc4_no_second_done", seen_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL be a multiple of BPC.
REQ-002 Parameter BPC, default 1, bits retired per compute cycle; legal values 1, 2, 4.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high.
REQ-005 Port flush, input, 1, pipeline flush (branch taken); cancels the operation in flight.
REQ-006 Port start, input, 1, request a new operation; sampled only in IDLE.
REQ-007 Port funct3, input, 3, RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 Port op_a, input, DATA_W, rs1 value (dividend or multiplicand).
REQ-009 Port op_b, input, DATA_W, rs2 value (divisor or multiplier).
REQ-010 Port rd_in, input, 5, destination register tag.
REQ-011 Port stall_req, output, 1, holds the IF/ID/EX stages while the unit is computing.
REQ-012 Port busy, output, 1, high in CALC and FIX.
REQ-013 Port done, output, 1, one-cycle pulse; result and rd_out are valid.
REQ-014 Port result, output, DATA_W, operation result.
REQ-015 Port rd_out, output, 5, tag captured at start.

Function
REQ-016 States SHALL be IDLE, CALC, FIX, DONE; N = DATA_W/BPC.
REQ-017 IDLE with start=1 and flush=0: op_a, op_b, funct3 and rd_in SHALL be latched, operands made absolute for signed ops, count cleared, and the state SHALL move to CALC.
REQ-018 CALC SHALL retire BPC bits per edge: shift-add for multiply (2*DATA_W product), restoring division for divide; after the Nth CALC edge the state SHALL move to FIX.
REQ-019 FIX SHALL apply sign correction (quotient sign = sign_a XOR sign_b; remainder sign = sign_a), select the high or low product half or the quotient or remainder, load result, then move to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 Latency: the start edge is T0; done SHALL be high in the cycle after edge T0+N+2 (DATA_W=32, BPC=1: after edge T0+34).
REQ-022 Divide by zero SHALL go IDLE->DONE at T0+1: DIV/DIVU result all-ones; REM/REMU result = op_a.
REQ-023 Signed overflow (op_a = most-negative value, op_b = -1, DIV/REM) SHALL go IDLE->DONE at T0+1: DIV result = op_a; REM result = 0.
REQ-024 MULHSU SHALL treat op_a as signed and op_b as unsigned; MULHU/DIVU/REMU SHALL treat both operands as unsigned; MUL SHALL return the low DATA_W bits.
REQ-025 stall_req SHALL be combinational and equal (IDLE AND start AND NOT flush) OR CALC OR FIX; it SHALL be 0 in DONE so the pipeline captures the result on that edge.
REQ-026 start SHALL be ignored outside IDLE; it SHALL NOT re-latch operands or restart the count.
REQ-027 flush=1 in any state SHALL force IDLE on the next edge with no done pulse; flush has priority over start in the same cycle.
REQ-028 result and rd_out SHALL hold their last value until the next FIX or fast-path DONE load.

Reset
REQ-029 reset=1 SHALL force IDLE on the next edge, overriding flush and start, including when an operation is in progress.
REQ-030 Reset values: done=0, busy=0, result=0, rd_out=0, count=0, all internal operand and accumulator registers 0; stall_req = 0 while reset is held.

Verification
REQ-031 MUL with op_a=7, op_b=-3, rd_in=5 -> done after edge T0+34; result=0xFFFFFFEB, rd_out=5; stall_req high for the 34 cycles before done.
REQ-032 MULH with op_a=0x80000000, op_b=0x80000000 -> result=0x40000000; MULHU with the same operands -> 0x40000000; MULHSU with op_a=-1, op_b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 DIV with op_a=-7, op_b=2 -> result=0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU with op_a=100, op_b=7 -> 14.
REQ-034 DIVU with op_a=123, op_b=0 -> done at T0+1 with result 0xFFFFFFFF; REM with op_a=0x80000000, op_b=-1 -> done at T0+1 with result 0.
REQ-035 Start a DIV, then pulse flush at cycle 10 -> IDLE next edge, no done pulse, stall_req low; a new start accepted next cycle completes normally. Repeat with reset instead of flush.
REQ-036 Pulse start again at cycle 5 of a MUL, with BPC=4 -> second start ignored; done after edge T0+10 with the first operation's result.
